mips_perf_monitor: RTL

- Passive observer downstream of the pipelined MIPS core. Consumes the core's per-cycle status outputs: stall, branch/zero, MemWrite, RegWrite, forwarding selects, writeback destination and data.
- Maintains saturating event counters, read through a registered select port.
- Captures register writebacks into a trace FIFO drained by a valid/ready consumer (bench scoreboard or debug port).
- Never drives the core; adding or removing it changes no core behaviour.

---
 rtl/mips_dbg_pkg.sv | 30 +++
 rtl/mips_trace_fifo.sv | 87 ++++++++
 rtl/mips_perf_monitor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mips_dbg_pkg.sv
// ---------------------------------------------------------------------------
// mips_dbg_pkg
// Shared types and constants for the MIPS debug / performance-monitor slice.
//   cnt_sel_e      : counter bank index, also the encoding of the cnt_sel port
//   trace_entry_t  : one captured register writeback {dest, data}
//   FWD_NONE       : forwarding-select value meaning "operand not forwarded"
//   NUM_CNT        : number of event counters in the bank
// ---------------------------------------------------------------------------
package mips_dbg_pkg;

  typedef enum logic [2:0] {
    CNT_CYCLES       = 3'd0,
    CNT_STALLS       = 3'd1,
    CNT_BR_TAKEN     = 3'd2,
    CNT_BR_NOT_TAKEN = 3'd3,
    CNT_FORWARDS     = 3'd4,
    CNT_MEM_WRITES   = 3'd5,
    CNT_REG_WRITES   = 3'd6,
    CNT_DROPS        = 3'd7
  } cnt_sel_e;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } trace_entry_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam int         NUM_CNT  = 8;

endpackage

// File: rtl/mips_trace_fifo.sv
// ---------------------------------------------------------------------------
// mips_trace_fifo
// Show-ahead FIFO of trace_entry_t used to buffer register writebacks.
// Ports:
//   clock, reset     : system clock, asynchronous active-low reset
//   clear            : synchronous flush (pointers back to 0)
//   push, push_entry : write request and payload
//   pop              : read request; ignored while empty
//   head             : entry at the read pointer, all-zero while empty
//   full, empty      : occupancy flags
// A push while full is accepted only if a pop frees the slot in the same
// cycle; otherwise it is discarded (the caller counts the drop).
// ---------------------------------------------------------------------------
module mips_trace_fifo
  import mips_dbg_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  trace_entry_t push_entry,
  input  logic         pop,
  output trace_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  trace_entry_t mem_q [DEPTH];
  logic         do_push_s;
  logic         do_pop_s;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop_s  = pop & ~empty;
  // Full with a simultaneous pop: the write reuses the slot being vacated.
  assign do_push_s = push & (~full | do_pop_s);

  // Next-state pointer computation, clear has priority.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = {(AW+1){1'b0}};
      rd_ptr_d = {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are never observable while empty, so no reset.
  always_ff @(posedge clock) begin
    if (do_push_s && !clear) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
    end
  end

  assign head = empty ? {5'd0, 32'd0} : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/mips_perf_monitor.sv
// ---------------------------------------------------------------------------
// mips_perf_monitor
// Passive observer of the pipelined MIPS core: a bank of saturating event
// counters plus a trace FIFO of register writebacks.
// Ports:
//   clock, reset        : system clock, asynchronous active-low reset
//   enable              : gates counting and trace capture
//   clear               : synchronous flush of counters, FIFO and overflow
//   stall_in .. write_data_in : core status observed each cycle
//   cnt_sel, cnt_data   : counter read port, one-cycle registered latency
//   trace_valid/dest/data, trace_ready : show-ahead trace drain interface
//   overflow            : sticky, set when a capture hit a full FIFO
// ---------------------------------------------------------------------------
module mips_perf_monitor
  import mips_dbg_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TRACE_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             stall_in,
  input  logic             branch_in,
  input  logic             zero_in,
  input  logic             mem_write_in,
  input  logic             reg_write_in,
  input  logic [1:0]       op_fa_in,
  input  logic [1:0]       op_fb_in,
  input  logic [4:0]       dest_in,
  input  logic [31:0]      write_data_in,
  input  logic [2:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_data,
  output logic             trace_valid,
  output logic [4:0]       trace_dest,
  output logic [31:0]      trace_data,
  input  logic             trace_ready,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q [NUM_CNT];
  logic [CNT_W-1:0] cnt_d [NUM_CNT];
  logic [1:0]       inc_s [NUM_CNT];
  logic [CNT_W:0]   sum_s;
  logic [CNT_W-1:0] cnt_data_q, cnt_data_d;
  logic             overflow_q, overflow_d;

  logic             wb_valid_s;
  logic             push_s;
  logic             drop_s;
  logic             full_s;
  logic             empty_s;
  trace_entry_t     push_entry_s;
  trace_entry_t     head_s;

  // A writeback to r0 is architecturally a no-op and is neither counted nor traced.
  assign wb_valid_s   = reg_write_in & (dest_in != 5'd0);
  assign push_s       = enable & wb_valid_s & ~stall_in;
  // Dropped only if nothing is popped in the same cycle to make room.
  assign drop_s       = push_s & full_s & ~(trace_ready & ~empty_s);
  assign push_entry_s = '{dest: dest_in, data: write_data_in};

  // Per-counter increment amounts for this cycle.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      inc_s[i] = 2'd0;
    end
    if (enable) begin
      inc_s[CNT_CYCLES]       = 2'd1;
      inc_s[CNT_STALLS]       = {1'b0, stall_in};
      inc_s[CNT_BR_TAKEN]     = {1'b0, branch_in & zero_in};
      inc_s[CNT_BR_NOT_TAKEN] = {1'b0, branch_in & ~zero_in};
      inc_s[CNT_FORWARDS]     = {1'b0, op_fa_in != FWD_NONE} +
                                {1'b0, op_fb_in != FWD_NONE};
      inc_s[CNT_MEM_WRITES]   = {1'b0, mem_write_in};
      inc_s[CNT_REG_WRITES]   = {1'b0, wb_valid_s};
      inc_s[CNT_DROPS]        = {1'b0, drop_s};
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        inc_s[i] = 2'd0;
      end
    end
  end

  // Saturating add: a carry out of the counter width means we passed the max.
  always_comb begin
    sum_s = {(CNT_W+1){1'b0}};
    for (int i = 0; i < NUM_CNT; i++) begin
      sum_s = {1'b0, cnt_q[i]} + {{(CNT_W-1){1'b0}}, inc_s[i]};
      if (clear) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (sum_s[CNT_W]) begin
        cnt_d[i] = CNT_MAX;
      end else begin
        cnt_d[i] = sum_s[CNT_W-1:0];
      end
    end
  end

  // Read-port and overflow next state; read samples pre-edge counter values.
  always_comb begin
    cnt_data_d = cnt_data_q;
    overflow_d = overflow_q;
    if (clear) begin
      cnt_data_d = {CNT_W{1'b0}};
      overflow_d = 1'b0;
    end else begin
      cnt_data_d = cnt_q[cnt_sel];
      overflow_d = overflow_q | drop_s;
    end
  end

  // Counter bank, read register and sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
      cnt_data_q <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      cnt_data_q <= cnt_data_d;
      overflow_q <= overflow_d;
    end
  end

  mips_trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (trace_ready),
    .head       (head_s),
    .full       (full_s),
    .empty      (empty_s)
  );

  assign cnt_data    = cnt_data_q;
  assign overflow    = overflow_q;
  assign trace_valid = ~empty_s;
  assign trace_dest  = head_s.dest;
  assign trace_data  = head_s.data;

endmodule
